// File: rtl/core_csr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : core_csr_loader
//  Description : Avalon-MM CSR initiator that halts the RV32I core, streams a
//                word image into imem, releases the core, polls its halted
//                status and returns the test gp value.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_csr_loader #(
   parameter logic [17:0] CTRL_ADDR       = 18'h00000,
   parameter logic [17:0] STATUS_ADDR     = 18'h00001,
   parameter logic [17:0] GP_ADDR         = 18'h00002,
   parameter logic [2:0]  IMEM_REGION     = 3'd1,
   parameter logic [31:0] HALT_VAL        = 32'h00000001,
   parameter logic [31:0] RUN_VAL         = 32'h00000010,
   parameter int          STATUS_HALT_BIT = 0,
   parameter int          RD_LATENCY      = 1,
   parameter int          POLL_INTERVAL   = 16,
   parameter logic [31:0] TIMEOUT_CYCLES  = 32'd1000000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [14:0] start_addr,
   input  logic [15:0] word_count,
   input  logic        s_valid,
   input  logic [31:0] s_data,
   output logic        s_ready,
   output logic [17:0] avm_address,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        timed_out,
   output logic [31:0] result_gp,
   output logic [15:0] words_loaded
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_HALT_WR   = 4'd1,
      S_LOAD_WAIT = 4'd2,
      S_LOAD_WR   = 4'd3,
      S_RUN_WR    = 4'd4,
      S_POLL_WAIT = 4'd5,
      S_POLL_RD   = 4'd6,
      S_POLL_CAP  = 4'd7,
      S_GP_RD     = 4'd8,
      S_GP_CAP    = 4'd9,
      S_DONE      = 4'd10
   } state_t;

   localparam logic [2:0]  LAT_LAST = 3'(RD_LATENCY - 1);
   localparam logic [31:0] POLL_RELOAD = 32'(POLL_INTERVAL);

   state_t      state;
   state_t      state_nxt;
   logic [14:0] base_addr;
   logic [15:0] count;
   logic [31:0] word_buf;
   logic [31:0] tmo_cnt;
   logic [31:0] poll_cnt;
   logic [2:0]  lat_cnt;

   logic        accept;
   logic        tmo_hit;
   logic        lat_done;
   logic        halted;
   logic        tmo_exit;
   logic [14:0] offset;

   assign accept   = ~avm_waitrequest;
   assign tmo_hit  = (TIMEOUT_CYCLES != 32'd0) && (tmo_cnt >= TIMEOUT_CYCLES);
   assign lat_done = (lat_cnt == LAT_LAST);
   assign halted   = avm_readdata[STATUS_HALT_BIT];
   // imem offset wraps naturally at 15 bits; the region bits are fixed
   assign offset   = base_addr + words_loaded[14:0];
   assign busy     = (state != S_IDLE);

   // state register; reset returns to IDLE immediately, dropping any request
   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // next-state decode and bus/stream outputs
   always_comb begin
      state_nxt     = state;
      s_ready       = 1'b0;
      avm_address   = 18'h0;
      avm_write     = 1'b0;
      avm_writedata = 32'h0;
      avm_read      = 1'b0;
      done          = 1'b0;
      tmo_exit      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_HALT_WR;
         end
         S_HALT_WR: begin
            avm_address   = CTRL_ADDR;
            avm_write     = 1'b1;
            avm_writedata = HALT_VAL;
            if (accept) state_nxt = (count == 16'd0) ? S_RUN_WR : S_LOAD_WAIT;
         end
         S_LOAD_WAIT: begin
            s_ready = 1'b1;
            if (s_valid) state_nxt = S_LOAD_WR;
         end
         S_LOAD_WR: begin
            avm_address   = {IMEM_REGION, offset};
            avm_write     = 1'b1;
            avm_writedata = word_buf;
            if (accept)
               state_nxt = (words_loaded + 16'd1 == count) ? S_RUN_WR : S_LOAD_WAIT;
         end
         S_RUN_WR: begin
            avm_address   = CTRL_ADDR;
            avm_write     = 1'b1;
            avm_writedata = RUN_VAL;
            if (accept) state_nxt = S_POLL_WAIT;
         end
         S_POLL_WAIT: begin
            if (tmo_hit) begin
               tmo_exit  = 1'b1;
               state_nxt = S_DONE;
            end else if (poll_cnt <= 32'd1) begin
               state_nxt = S_POLL_RD;
            end
         end
         S_POLL_RD: begin
            // an issued status read always runs to completion, even past timeout
            avm_address = STATUS_ADDR;
            avm_read    = 1'b1;
            if (accept) state_nxt = S_POLL_CAP;
         end
         S_POLL_CAP: begin
            if (lat_done) begin
               if (halted) begin
                  state_nxt = S_GP_RD;
               end else if (tmo_hit) begin
                  tmo_exit  = 1'b1;
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_POLL_WAIT;
               end
            end
         end
         S_GP_RD: begin
            avm_address = GP_ADDR;
            avm_read    = 1'b1;
            if (accept) state_nxt = S_GP_CAP;
         end
         S_GP_CAP: begin
            if (lat_done) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // sequence datapath: latched arguments, word buffer, counters and results
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         base_addr    <= 15'h0;
         count        <= 16'h0;
         word_buf     <= 32'h0;
         tmo_cnt      <= 32'h0;
         poll_cnt     <= 32'h0;
         lat_cnt      <= 3'h0;
         timed_out    <= 1'b0;
         result_gp    <= 32'h0;
         words_loaded <= 16'h0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  base_addr    <= start_addr;
                  count        <= word_count;
                  words_loaded <= 16'h0;
                  timed_out    <= 1'b0;
                  result_gp    <= 32'h0;
               end
            end
            S_LOAD_WAIT: begin
               if (s_valid) word_buf <= s_data;
            end
            S_LOAD_WR: begin
               if (accept) words_loaded <= words_loaded + 16'd1;
            end
            S_RUN_WR: begin
               if (accept) begin
                  tmo_cnt  <= 32'h0;
                  poll_cnt <= POLL_RELOAD;
               end
            end
            S_POLL_WAIT: begin
               poll_cnt <= poll_cnt - 32'd1;
            end
            S_POLL_RD, S_GP_RD: begin
               if (accept) lat_cnt <= 3'h0;
            end
            S_POLL_CAP: begin
               lat_cnt <= lat_cnt + 3'd1;
               if (lat_done && !halted) poll_cnt <= POLL_RELOAD;
            end
            S_GP_CAP: begin
               lat_cnt <= lat_cnt + 3'd1;
               if (lat_done) result_gp <= avm_readdata;
            end
            default: ;
         endcase

         // timeout counter saturates once the limit is reached
         if ((state == S_POLL_WAIT || state == S_POLL_RD || state == S_POLL_CAP) && !tmo_hit)
            tmo_cnt <= tmo_cnt + 32'd1;

         if (tmo_exit) timed_out <= 1'b1;
      end
   end

endmodule
`default_nettype wire
